// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: data-side bus controller for the processor's data port, covering a synchronous RAM with read wait states plus board I/O.
//   Clock, Reset                 single clock, synchronous active-high reset
//   Enable                       0 freezes FSM, counters and all writes
//   DataAddr/DataOut/WriteData/ReadData -> DataIn/DataWaitreq   processor side
//   RamAddr/RamWrData/RamWrEn <- RamQ                          RAM side
//   SW, KEY (async in) -> synchronised;  LEDR, HEX registered outputs
module data_bus_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int RAM_AW      = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int NUM_HEX     = 6,
    parameter int LED_W       = 10
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [ADDR_W-1:0]    DataAddr,
    input  logic [DATA_W-1:0]    DataOut,
    input  logic                 WriteData,
    input  logic                 ReadData,
    output logic [DATA_W-1:0]    DataIn,
    output logic                 DataWaitreq,
    output logic [RAM_AW-1:0]    RamAddr,
    output logic [DATA_W-1:0]    RamWrData,
    output logic                 RamWrEn,
    input  logic [DATA_W-1:0]    RamQ,
    input  logic [LED_W-1:0]     SW,
    input  logic [3:0]           KEY,
    output logic [LED_W-1:0]     LEDR,
    output logic [7*NUM_HEX-1:0] HEX
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [15:0] cnt, cnt_n, wait_cnt;
    logic [LED_W-1:0] sw_m, sw_s;
    logic [3:0] key_m, key_s;
    logic [6:0] hex_rd;
    logic [ADDR_W-1:0] hex_idx;
    logic ram_hit, led_sel, hex_sel, sw_sel, key_sel, cnt_sel, rd, wr;
    assign rd      = ReadData & ~WriteData;
    assign wr      = WriteData;
    assign ram_hit = (DataAddr >> RAM_AW) == '0;
    assign led_sel = DataAddr == ADDR_W'(16'h1000);
    assign hex_idx = DataAddr - ADDR_W'(16'h2000);
    assign hex_sel = (DataAddr >= ADDR_W'(16'h2000)) && (hex_idx < ADDR_W'(NUM_HEX));
    assign sw_sel  = DataAddr == ADDR_W'(16'h3000);
    assign key_sel = DataAddr == ADDR_W'(16'h3001);
    assign cnt_sel = DataAddr == ADDR_W'(16'h3002);
    assign RamAddr   = DataAddr[RAM_AW-1:0];
    assign RamWrData = DataOut;
    assign RamWrEn   = wr & ram_hit & (state == IDLE) & Enable;
    // WAIT holds the stall while the counter runs down; leaving on cnt==1 gives exactly WAIT_CYCLES stall cycles
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        DataWaitreq = 1'b0;
        if (state == IDLE) begin
            if (rd && ram_hit) begin
                DataWaitreq = 1'b1;
                cnt_n       = 16'(WAIT_CYCLES - 1);
                state_n     = (WAIT_CYCLES > 1) ? WAIT : DONE;
            end
        end else if (state == WAIT) begin
            DataWaitreq = 1'b1;
            cnt_n       = cnt - 16'd1;
            state_n     = (cnt == 16'd1) ? DONE : WAIT;
        end else begin
            state_n = IDLE;
        end
    end
    always_comb begin
        hex_rd = '0;
        for (int i = 0; i < NUM_HEX; i++)
            if (hex_idx == ADDR_W'(i)) hex_rd = HEX[7*i +: 7];
    end
    assign DataIn = !rd     ? '0 :
                    ram_hit ? ((state == DONE) ? RamQ : '0) :
                    led_sel ? DATA_W'(LEDR) :
                    hex_sel ? DATA_W'(hex_rd) :
                    sw_sel  ? DATA_W'(sw_s) :
                    key_sel ? DATA_W'(key_s) :
                    cnt_sel ? DATA_W'(wait_cnt) : '0;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            LEDR     <= '0;
            HEX      <= '1;
            sw_m     <= '0;
            sw_s     <= '0;
            key_m    <= '0;
            key_s    <= '0;
        end else begin
            sw_m  <= SW;
            sw_s  <= sw_m;
            key_m <= KEY;
            key_s <= key_m;
            if (Enable) begin
                state <= state_n;
                cnt   <= cnt_n;
                // a clear on the same cycle as a stall wins over the increment
                if (wr && cnt_sel) wait_cnt <= '0;
                else if (DataWaitreq && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
                if (wr && led_sel) LEDR <= DataOut[LED_W-1:0];
                for (int i = 0; i < NUM_HEX; i++)
                    if (wr && hex_sel && hex_idx == ADDR_W'(i)) HEX[7*i +: 7] <= DataOut[6:0];
            end
        end
    end
endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb_data_bus_ctrl: directed checks of data_bus_ctrl with one and three RAM wait states.
module tb_data_bus_ctrl;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, wr = 1'b0, rd = 1'b0, sel1 = 1'b0;
    logic [15:0] addr = '0, dout = '0;
    logic [9:0] sw = '0;
    logic [3:0] key = 4'hF;
    logic [15:0] d1, d3, wd1, wd3, q1, q3;
    logic [11:0] ra1, ra3, a1;
    logic [11:0] p3 [0:2];
    logic wq1, wq3, we1, we3, last_we;
    logic [9:0] led1, led3;
    logic [41:0] hex1, hex3;
    logic [15:0] mem1 [0:4095];
    logic [15:0] mem3 [0:4095];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    data_bus_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .Clock(clk), .Reset(rst), .Enable(en), .DataAddr(addr), .DataOut(dout),
        .WriteData(wr), .ReadData(rd & sel1), .DataIn(d1), .DataWaitreq(wq1),
        .RamAddr(ra1), .RamWrData(wd1), .RamWrEn(we1), .RamQ(q1),
        .SW(sw), .KEY(key), .LEDR(led1), .HEX(hex1));

    data_bus_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .Clock(clk), .Reset(rst), .Enable(en), .DataAddr(addr), .DataOut(dout),
        .WriteData(wr), .ReadData(rd & ~sel1), .DataIn(d3), .DataWaitreq(wq3),
        .RamAddr(ra3), .RamWrData(wd3), .RamWrEn(we3), .RamQ(q3),
        .SW(sw), .KEY(key), .LEDR(led3), .HEX(hex3));

    always @(posedge clk) begin
        if (we1) mem1[ra1] <= wd1;
        a1 <= ra1;
        if (we3) mem3[ra3] <= wd3;
        p3[0] <= ra3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q1 = mem1[a1];
    assign q3 = mem3[p3[2]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
        @(posedge clk); #1; addr = a; dout = v; wr = 1'b1; rd = 1'b0;
        @(negedge clk); last_we = we3;
        @(posedge clk); #1; wr = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
        @(posedge clk); #1; addr = a; rd = 1'b1; wr = 1'b0;
        @(negedge clk);
        chk(tag, sel1 ? d1 : d3, exp);
        chk({tag, "_wq"}, sel1 ? wq1 : wq3, 0);
        @(posedge clk); #1; rd = 1'b0;
    endtask

    task automatic wait_data(input int n, input logic [15:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); chk({tag, "_stall"}, sel1 ? wq1 : wq3, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_wq0"}, sel1 ? wq1 : wq3, 0);
        chk({tag, "_data"}, sel1 ? d1 : d3, exp);
    endtask

    task automatic ram_read(input logic [15:0] a, input logic [15:0] exp, input int n, input string tag);
        @(posedge clk); #1; addr = a; rd = 1'b1; wr = 1'b0;
        wait_data(n, exp, tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        io_read(16'h1000, 16'h0000, "rst_led");
        io_read(16'h2000, 16'h007F, "rst_hex0");
        io_read(16'h3002, 16'h0000, "rst_cnt");
        chk("rst_ledr", led3, 0);
        chk("rst_hex", hex3, {42{1'b1}});

        bus_write(16'h0005, 16'h1234);
        chk("ram_we", last_we, 1);
        sel1 = 1'b1;
        ram_read(16'h0005, 16'h1234, 1, "w1");
        io_read(16'h3002, 16'h0001, "w1_cnt");
        sel1 = 1'b0;

        bus_write(16'h0010, 16'hA010);
        bus_write(16'h0011, 16'hA011);
        ram_read(16'h0010, 16'hA010, 3, "b2b0");
        ram_read(16'h0011, 16'hA011, 3, "b2b1");
        io_read(16'h3002, 16'h0006, "w3_cnt");
        bus_write(16'h3002, 16'h5555);
        io_read(16'h3002, 16'h0000, "cnt_clr");

        bus_write(16'h1000, 16'h03FF);
        chk("ledr", led3, 10'h3FF);
        bus_write(16'h2003, 16'h0040);
        chk("hex3", hex3[27:21], 7'h40);
        chk("hex0_kept", hex3[6:0], 7'h7F);
        io_read(16'h2003, 16'h0040, "hex3_rd");
        bus_write(16'h4000, 16'hBEEF);
        chk("unmapped_we", last_we, 0);
        io_read(16'h4000, 16'h0000, "unmapped_rd");

        @(posedge clk); #1; sw = 10'h2A5; key = 4'b1110; addr = 16'h3000; rd = 1'b1;
        @(negedge clk); chk("sw_lat0", d3, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk); chk("sw_lat1", d3, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk); chk("sw_lat2", d3, 16'h02A5);
        io_read(16'h3001, 16'h000E, "key");

        @(posedge clk); #1; addr = 16'h1000; dout = 16'h0001; wr = 1'b1; rd = 1'b1;
        @(negedge clk); chk("rw_data", d3, 0); chk("rw_wq", wq3, 0);
        @(posedge clk); #1; wr = 1'b0; rd = 1'b0;
        chk("rw_ledr", led3, 10'h001);

        en = 1'b0;
        bus_write(16'h1000, 16'h0055);
        chk("en_hold", led3, 10'h001);
        en = 1'b1;

        @(posedge clk); #1; addr = 16'h0010; rd = 1'b1; wr = 1'b0;
        @(negedge clk); chk("rstw_0", wq3, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("rstw_1", wq3, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("rstw_2", wq3, 1);
        @(posedge clk); #1; rst = 1'b0;
        wait_data(3, 16'hA010, "rstw");
        @(posedge clk); #1; rd = 1'b0;
        chk("rstw_ledr", led3, 0);
        io_read(16'h3002, 16'h0003, "rstw_cnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
